delay_event_scheduler: RTL and testbench

Synthesizable multi-slot timer engine. It accepts tagged "fire after N cycles" requests at up to one per cycle and keeps many requests in flight concurrently. Each request completes after its own programmed delay, and completions are counted. It is the RTL stage that feeds per-cycle spawned delayed processes into the completion counter/checker downstream. It replaces behavioural fork/join_none delays in that flow.

---
 rtl/delay_event_pkg.sv | 38 +++
 rtl/delay_event_scheduler_if.sv | 42 ++++
 rtl/delay_event_slot.sv | 87 ++++++++
 rtl/delay_event_scheduler.sv | 148 ++++++++++++++
 tb/tb_delay_event_scheduler.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/delay_event_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : delay_event_pkg                                               |
// | Purpose  : Shared types and helpers for the delay event scheduler:       |
// |            slot state encoding, a slot record type and the width        |
// |            helper for the in-flight counter.                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package delay_event_pkg;

   localparam int C_DEF_NUM_SLOTS = 16;
   localparam int C_DEF_DELAY_W   = 8;
   localparam int C_DEF_TAG_W     = 4;
   localparam int C_DEF_CNT_W     = 32;

   // Per-slot life cycle: free, counting down, expired and waiting for drain.
   typedef enum logic [1:0] {
      SLOT_IDLE  = 2'd0,
      SLOT_COUNT = 2'd1,
      SLOT_PEND  = 2'd2
   } slot_state_e;

   // Architectural view of one slot at the default widths.
   typedef struct packed {
      slot_state_e                state;
      logic [C_DEF_DELAY_W-1:0]   remaining;
      logic [C_DEF_TAG_W-1:0]     tag;
   } slot_t;

   // The in-flight counter must be able to represent 0..num_slots inclusive.
   function automatic int inflight_width(input int num_slots);
      return $clog2(num_slots + 1);
   endfunction

   localparam int C_DEF_INFLIGHT_W = inflight_width(C_DEF_NUM_SLOTS);

endpackage
`default_nettype wire

// File: rtl/delay_event_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : delay_event_scheduler_if                                     |
// | Purpose   : Request/completion handshakes and status of the scheduler.   |
// | Ports     : req_valid/req_ready/req_delay/req_tag  request channel       |
// |             done_valid/done_ready/done_tag          completion channel    |
// |             in_flight, cnt                          status               |
// |             modport master = requester/consumer, slave = scheduler       |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface delay_event_scheduler_if
   import delay_event_pkg::*;
#(
   parameter int NUM_SLOTS = 16,
   parameter int DELAY_W   = 8,
   parameter int TAG_W     = 4,
   parameter int CNT_W     = 32
);
   localparam int INFLIGHT_W = inflight_width(NUM_SLOTS);

   logic                  req_valid;
   logic                  req_ready;
   logic [DELAY_W-1:0]    req_delay;
   logic [TAG_W-1:0]      req_tag;
   logic                  done_valid;
   logic                  done_ready;
   logic [TAG_W-1:0]      done_tag;
   logic [INFLIGHT_W-1:0] in_flight;
   logic [CNT_W-1:0]      cnt;

   modport master (
      output req_valid, req_delay, req_tag, done_ready,
      input  req_ready, done_valid, done_tag, in_flight, cnt
   );

   modport slave (
      input  req_valid, req_delay, req_tag, done_ready,
      output req_ready, done_valid, done_tag, in_flight, cnt
   );

endinterface
`default_nettype wire

// File: rtl/delay_event_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : delay_event_slot                                              |
// | Purpose  : One timer slot: IDLE -> COUNT on load, COUNT -> PEND when the |
// |            down-counter expires, PEND -> IDLE when cleared.              |
// | Ports    : clk, rst_n       clock, async active-low reset                |
// |            load             accept a request into this slot              |
// |            load_delay/tag   request delay (0 treated as 1) and tag       |
// |            clear            completion of this slot handshaken           |
// |            is_idle/is_pend  registered state decodes                     |
// |            tag              stored request tag                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module delay_event_slot
   import delay_event_pkg::*;
#(
   parameter int DELAY_W = 8,
   parameter int TAG_W   = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [DELAY_W-1:0] load_delay,
   input  logic [TAG_W-1:0]   load_tag,
   input  logic               clear,
   output logic               is_idle,
   output logic               is_pend,
   output logic [TAG_W-1:0]   tag
);

   slot_state_e        r_state;
   slot_state_e        w_state_nxt;
   logic [DELAY_W-1:0] r_remaining;
   logic [DELAY_W-1:0] w_remaining_nxt;
   logic [TAG_W-1:0]   r_tag;
   logic [TAG_W-1:0]   w_tag_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= SLOT_IDLE;
         r_remaining <= '0;
         r_tag       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_tag       <= w_tag_nxt;
      end
   end

   // The counter is loaded with the full delay on the accepting edge and the
   // slot turns PEND on the edge where it would decrement to zero, so the
   // completion becomes visible exactly 'delay' cycles after acceptance.
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_tag_nxt       = r_tag;
      case (r_state)
         SLOT_IDLE: begin
            if (load) begin
               w_state_nxt     = SLOT_COUNT;
               w_remaining_nxt = (load_delay == '0) ? DELAY_W'(1) : load_delay;
               w_tag_nxt       = load_tag;
            end
         end
         SLOT_COUNT: begin
            w_remaining_nxt = r_remaining - DELAY_W'(1);
            if (r_remaining <= DELAY_W'(1)) begin
               w_state_nxt = SLOT_PEND;
            end
         end
         SLOT_PEND: begin
            if (clear) begin
               w_state_nxt = SLOT_IDLE;
            end
         end
         default: begin
            w_state_nxt = SLOT_IDLE;
         end
      endcase
   end

   assign is_idle = (r_state == SLOT_IDLE);
   assign is_pend = (r_state == SLOT_PEND);
   assign tag     = r_tag;

endmodule
`default_nettype wire

// File: rtl/delay_event_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : delay_event_scheduler                                         |
// | Purpose  : Multi-slot timer engine. Accepts tagged "fire after N cycles" |
// |            requests (one per cycle max), runs them concurrently and      |
// |            returns each tag on a valid/ready completion channel, counting |
// |            handshaken completions.                                       |
// | Ports    : clk, rst_n   clock, async active-low reset                    |
// |            bus (slave)  request channel, completion channel, in_flight,  |
// |                         cnt                                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module delay_event_scheduler
   import delay_event_pkg::*;
#(
   parameter int NUM_SLOTS = 16,
   parameter int DELAY_W   = 8,
   parameter int TAG_W     = 4,
   parameter int CNT_W     = 32
)(
   input  logic                   clk,
   input  logic                   rst_n,
   delay_event_scheduler_if.slave bus
);

   localparam int IDX_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int INFLIGHT_W = inflight_width(NUM_SLOTS);

   logic [NUM_SLOTS-1:0]            w_idle;
   logic [NUM_SLOTS-1:0]            w_pend;
   logic [NUM_SLOTS-1:0]            w_load;
   logic [NUM_SLOTS-1:0]            w_clear;
   logic [NUM_SLOTS-1:0][TAG_W-1:0] w_slot_tag;

   logic                  w_free_any;
   logic [IDX_W-1:0]      w_free_idx;
   logic                  w_pend_any;
   logic [IDX_W-1:0]      w_pend_idx;
   logic [IDX_W-1:0]      w_sel_idx;
   logic                  w_accept;
   logic                  w_done_valid;
   logic                  w_handshake;

   logic                  r_lock_valid;
   logic [IDX_W-1:0]      r_lock_idx;
   logic [INFLIGHT_W-1:0] r_in_flight;
   logic [CNT_W-1:0]      r_cnt;

   // ------------------------------------------------------------------
   // Slot array
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign w_load[gi]  = w_accept    && (w_free_idx == IDX_W'(gi));
      assign w_clear[gi] = w_handshake && (w_sel_idx  == IDX_W'(gi));

      delay_event_slot #(
         .DELAY_W (DELAY_W),
         .TAG_W   (TAG_W)
      ) u_slot (
         .clk        (clk),
         .rst_n      (rst_n),
         .load       (w_load[gi]),
         .load_delay (bus.req_delay),
         .load_tag   (bus.req_tag),
         .clear      (w_clear[gi]),
         .is_idle    (w_idle[gi]),
         .is_pend    (w_pend[gi]),
         .tag        (w_slot_tag[gi])
      );
   end

   // ------------------------------------------------------------------
   // Lowest-index priority encoders (free slot, pending slot)
   // ------------------------------------------------------------------
   always_comb begin
      w_free_any = 1'b0;
      w_free_idx = '0;
      w_pend_any = 1'b0;
      w_pend_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (w_idle[i]) begin
            w_free_any = 1'b1;
            w_free_idx = IDX_W'(i);
         end
         if (w_pend[i]) begin
            w_pend_any = 1'b1;
            w_pend_idx = IDX_W'(i);
         end
      end
   end

   // Slot state is registered, so readiness never depends on done_ready.
   assign w_accept = bus.req_valid && w_free_any;

   // ------------------------------------------------------------------
   // Completion presentation with lock
   // ------------------------------------------------------------------
   // Once a completion has been shown and not taken, the lock pins the
   // selection so a lower slot expiring later cannot swap the tag under
   // the consumer. A locked slot is PEND by construction.
   assign w_sel_idx    = r_lock_valid ? r_lock_idx : w_pend_idx;
   assign w_done_valid = r_lock_valid || w_pend_any;
   assign w_handshake  = w_done_valid && bus.done_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_valid <= 1'b0;
         r_lock_idx   <= '0;
      end else if (w_handshake) begin
         r_lock_valid <= 1'b0;
      end else if (w_done_valid) begin
         r_lock_valid <= 1'b1;
         r_lock_idx   <= w_sel_idx;
      end
   end

   // ------------------------------------------------------------------
   // Occupancy and completion counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_flight <= '0;
      end else if (w_accept && !w_handshake) begin
         r_in_flight <= r_in_flight + INFLIGHT_W'(1);
      end else if (!w_accept && w_handshake) begin
         r_in_flight <= r_in_flight - INFLIGHT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_handshake) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.req_ready  = w_free_any;
   assign bus.done_valid = w_done_valid;
   assign bus.done_tag   = w_done_valid ? w_slot_tag[w_sel_idx] : '0;
   assign bus.in_flight  = r_in_flight;
   assign bus.cnt        = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_delay_event_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_delay_event_scheduler                                      |
// | Purpose  : Self-checking bench for delay_event_scheduler. A reference    |
// |            model tracks each slot by absolute expiry time and is checked |
// |            against the DUT every cycle on the falling edge.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_delay_event_scheduler;

   localparam int NS = 16;
   localparam int DW = 8;
   localparam int TW = 4;
   localparam int CW = 32;

   logic clk;
   logic rst_n;

   delay_event_scheduler_if #(.NUM_SLOTS(NS), .DELAY_W(DW), .TAG_W(TW), .CNT_W(CW)) bus ();

   delay_event_scheduler #(
      .NUM_SLOTS (NS),
      .DELAY_W   (DW),
      .TAG_W     (TW),
      .CNT_W     (CW)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a slot is busy from acceptance until its completion is
   // taken; it is pending once the edge counter reaches its expiry time.
   bit            m_busy   [NS];
   int            m_expire [NS];
   logic [TW-1:0] m_tag    [NS];
   int            m_lock;
   logic [CW-1:0] m_cnt;
   int            m_now;

   int n_checks;
   int n_fail;

   task automatic model_reset();
      for (int s = 0; s < NS; s++) begin
         m_busy[s]   = 1'b0;
         m_expire[s] = 0;
         m_tag[s]    = '0;
      end
      m_lock = -1;
      m_cnt  = '0;
      m_now  = 0;
   endtask

   function automatic int m_present();
      int r;
      r = -1;
      if (m_lock >= 0) begin
         r = m_lock;
      end else begin
         for (int s = NS - 1; s >= 0; s--) begin
            if (m_busy[s] && (m_now >= m_expire[s])) r = s;
         end
      end
      return r;
   endfunction

   task automatic model_edge(input bit rv, input logic [DW-1:0] d,
                             input logic [TW-1:0] t, input bit dr);
      int p;
      int fs;
      p  = m_present();
      fs = -1;
      for (int s = NS - 1; s >= 0; s--) begin
         if (!m_busy[s]) fs = s;
      end
      m_now = m_now + 1;
      if (p >= 0 && dr) begin
         m_busy[p] = 1'b0;
         m_lock    = -1;
         m_cnt     = m_cnt + 1;
      end else if (p >= 0) begin
         m_lock = p;
      end
      if (rv && fs >= 0) begin
         m_busy[fs]   = 1'b1;
         m_tag[fs]    = t;
         m_expire[fs] = m_now + ((d == 0) ? 1 : int'(d));
      end
   endtask

   task automatic check_outputs(input string label, input bit in_reset);
      int            p;
      logic          exp_ready;
      logic          exp_dv;
      logic [TW-1:0] exp_tag;
      logic [4:0]    exp_if;
      exp_ready = 1'b0;
      exp_if    = '0;
      for (int s = 0; s < NS; s++) begin
         if (!m_busy[s]) exp_ready = 1'b1;
         else            exp_if    = exp_if + 5'd1;
      end
      p       = m_present();
      exp_dv  = (p >= 0);
      exp_tag = '0;
      if (p >= 0) exp_tag = m_tag[p];

      n_checks++;
      assert (bus.req_ready === exp_ready) else begin
         n_fail++;
         $error("FAIL %s req_ready observed=%0b expected=%0b", label, bus.req_ready, exp_ready);
      end
      n_checks++;
      assert (bus.done_valid === exp_dv) else begin
         n_fail++;
         $error("FAIL %s done_valid observed=%0b expected=%0b", label, bus.done_valid, exp_dv);
      end
      n_checks++;
      assert (bus.in_flight === exp_if) else begin
         n_fail++;
         $error("FAIL %s in_flight observed=%0d expected=%0d", label, bus.in_flight, exp_if);
      end
      n_checks++;
      assert (bus.cnt === m_cnt) else begin
         n_fail++;
         $error("FAIL %s cnt observed=%0d expected=%0d", label, bus.cnt, m_cnt);
      end
      if (exp_dv || in_reset) begin
         n_checks++;
         assert (bus.done_tag === exp_tag) else begin
            n_fail++;
            $error("FAIL %s done_tag observed=%0h expected=%0h", label, bus.done_tag, exp_tag);
         end
      end
   endtask

   // One clock: check current outputs, drive the next inputs, advance the
   // model across the rising edge, then return at the following falling edge.
   task automatic cycle(input bit rv, input logic [DW-1:0] d, input logic [TW-1:0] t,
                        input bit dr, input string label);
      check_outputs(label, 1'b0);
      bus.req_valid  = rv;
      bus.req_delay  = d;
      bus.req_tag    = t;
      bus.done_ready = dr;
      @(posedge clk);
      model_edge(rv, d, t, dr);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit dr, input string label);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, dr, label);
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_delay  = '0;
      bus.req_tag    = '0;
      bus.done_ready = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs("reset", 1'b1);
      rst_n = 1'b1;

      // Streaming: one request per cycle, fixed delay, consumer always ready.
      for (int i = 0; i < 100; i++) cycle(1'b1, 8'd10, TW'(i % 16), 1'b1, "stream");
      idle(20, 1'b1, "stream_drain");

      // Minimum latency: delay 0 and delay 1 both complete one cycle later.
      cycle(1'b1, 8'd0, 4'hA, 1'b1, "delay0");
      idle(3, 1'b1, "delay0_wait");
      cycle(1'b1, 8'd1, 4'h5, 1'b1, "delay1");
      idle(3, 1'b1, "delay1_wait");

      // Fill every slot, then keep requesting while full.
      for (int i = 0; i < NS + 3; i++) cycle(1'b1, 8'd40, TW'(i), 1'b1, "full");
      idle(60, 1'b1, "full_drain");

      // Three requests expiring on the same edge.
      cycle(1'b1, 8'd3, 4'h1, 1'b1, "same_exp");
      cycle(1'b1, 8'd2, 4'h2, 1'b1, "same_exp");
      cycle(1'b1, 8'd1, 4'h3, 1'b1, "same_exp");
      idle(6, 1'b1, "same_exp_drain");

      // Backpressure: higher slot presented first, lower slot expires later.
      cycle(1'b1, 8'd4, 4'h7, 1'b0, "lock");
      cycle(1'b1, 8'd1, 4'h9, 1'b0, "lock");
      idle(8, 1'b0, "lock_hold");
      idle(6, 1'b1, "lock_drain");

      // Randomized traffic with random backpressure.
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 3) != 0, DW'($urandom_range(0, 20)), TW'($urandom),
               $urandom_range(0, 2) != 0, "rand");
      end
      idle(80, 1'b1, "rand_drain");

      // One pending and six counting, then reset mid-cycle.
      cycle(1'b1, 8'd1, 4'hC, 1'b0, "pre_rst");
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'd30, TW'(i), 1'b0, "pre_rst");
      #2;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.done_ready = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst", 1'b1);
      @(negedge clk);
      check_outputs("rst_hold", 1'b1);
      rst_n = 1'b1;
      idle(40, 1'b1, "post_rst");

      for (int i = 0; i < 150; i++) begin
         cycle($urandom_range(0, 1) != 0, DW'($urandom_range(0, 12)), TW'($urandom),
               $urandom_range(0, 3) != 0, "rand2");
      end
      idle(60, 1'b1, "final_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
